// File: rtl/div_ocho_bits_if.sv
// Handshake bundle for the 8/4 restoring divider: operands and start in, results and status out.
interface div_ocho_bits_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  iStart;
  logic [DIVIDEND_W-1:0] iA;
  logic [DIVISOR_W-1:0]  iB;
  logic                  oBusy;
  logic                  oDone;
  logic [DIVIDEND_W-1:0] oQ;
  logic [DIVISOR_W-1:0]  oR;
  logic                  oDivZero;

  modport master (
    output iStart, iA, iB,
    input  oBusy, oDone, oQ, oR, oDivZero
  );

  modport slave (
    input  iStart, iA, iB,
    output oBusy, oDone, oQ, oR, oDivZero
  );
endinterface

// File: rtl/div_ocho_bits.sv
// Sequential restoring divider, one quotient bit per clock, with start/busy/done handshake.
module div_ocho_bits #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input logic             Clock,
  input logic             Reset,
  div_ocho_bits_if.slave  bus
);
  localparam int CW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [DIVIDEND_W-1:0] shreg;
  logic [DIVISOR_W-1:0]  dreg;
  logic [DIVISOR_W-1:0]  rem;
  logic [CW-1:0]         count;

  logic [DIVISOR_W:0]    p;
  logic                  ge;
  logic [DIVISOR_W-1:0]  r_next;
  logic [DIVIDEND_W-1:0] sh_next;

  // Dividend bits leave the top of shreg while quotient bits enter at the bottom,
  // so after DIVIDEND_W steps the register holds the quotient.
  always_comb begin
    p       = {rem, shreg[DIVIDEND_W-1]};
    ge      = (p >= {1'b0, dreg});
    r_next  = ge ? DIVISOR_W'(p - {1'b0, dreg}) : p[DIVISOR_W-1:0];
    sh_next = {shreg[DIVIDEND_W-2:0], ge};
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      shreg        <= '0;
      dreg         <= '0;
      rem          <= '0;
      count        <= '0;
      bus.oBusy    <= 1'b0;
      bus.oDone    <= 1'b0;
      bus.oQ       <= '0;
      bus.oR       <= '0;
      bus.oDivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            if (bus.iB != '0) begin
              shreg     <= bus.iA;
              dreg      <= bus.iB;
              rem       <= '0;
              count     <= CW'(DIVIDEND_W - 1);
              bus.oBusy <= 1'b1;
              state     <= RUN;
            end else begin
              bus.oQ       <= '1;
              bus.oR       <= '0;
              bus.oDivZero <= 1'b1;
              bus.oDone    <= 1'b1;
              state        <= DONE;
            end
          end
        end
        RUN: begin
          shreg <= sh_next;
          rem   <= r_next;
          if (count == '0) begin
            bus.oQ       <= sh_next;
            bus.oR       <= r_next;
            bus.oDivZero <= 1'b0;
            bus.oBusy    <= 1'b0;
            bus.oDone    <= 1'b1;
            state        <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: begin
          bus.oDone <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          bus.oBusy <= 1'b0;
          bus.oDone <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_ocho_bits.sv
// Scoreboard bench for div_ocho_bits: directed cases, exhaustive sweep and random traffic.
module tb_div_ocho_bits;
  logic Clock = 1'b0;
  logic Reset = 1'b1;

  div_ocho_bits_if #(.DIVIDEND_W(8), .DIVISOR_W(4)) bus ();
  div_ocho_bits dut (.Clock(Clock), .Reset(Reset), .bus(bus));

  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
    int         e0;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_start = 0;
  int   n_done = 0;
  int   busy_cnt = 0;

  logic [7:0] prev_q;
  logic [3:0] prev_r;
  logic       prev_dz;
  bit         have_prev = 0;

  // Monitor: samples 1 time unit after each rising edge
  always @(posedge Clock) begin
    exp_t e;
    cyc++;
    #1;
    if (Reset) begin
      busy_cnt = 0;
    end else begin
      if (bus.oBusy) busy_cnt++;
      if (bus.oDone) begin
        n_done++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: done seen with no pending op, q=%0d r=%0d", bus.oQ, bus.oR);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bus.oQ !== e.q || bus.oR !== e.r || bus.oDivZero !== e.dz) begin
            failures++;
            $display("FAIL result %0d/%0d: got q=%0d r=%0d dz=%0b, need q=%0d r=%0d dz=%0b",
                     e.a, e.b, bus.oQ, bus.oR, bus.oDivZero, e.q, e.r, e.dz);
          end
          checks++;
          if (cyc != e.e0 + (e.dz ? 0 : 8)) begin
            failures++;
            $display("FAIL latency %0d/%0d: done %0d cycles after start, need %0d",
                     e.a, e.b, cyc - e.e0, e.dz ? 0 : 8);
          end
          checks++;
          if (busy_cnt != (e.dz ? 0 : 8)) begin
            failures++;
            $display("FAIL busy_len %0d/%0d: busy for %0d cycles, need %0d",
                     e.a, e.b, busy_cnt, e.dz ? 0 : 8);
          end
        end
        busy_cnt = 0;
      end else if (have_prev) begin
        checks++;
        if (bus.oQ !== prev_q || bus.oR !== prev_r || bus.oDivZero !== prev_dz) begin
          failures++;
          $display("FAIL hold: results changed without done, q=%0d r=%0d dz=%0b, need q=%0d r=%0d dz=%0b",
                   bus.oQ, bus.oR, bus.oDivZero, prev_q, prev_r, prev_dz);
        end
      end
    end
    prev_q    = bus.oQ;
    prev_r    = bus.oR;
    prev_dz   = bus.oDivZero;
    have_prev = 1;
  end

  task automatic go(input logic [7:0] a, input logic [3:0] b, input bit expect_it, input int gap);
    exp_t e;
    @(negedge Clock);
    bus.iStart = 1'b1;
    bus.iA     = a;
    bus.iB     = b;
    if (expect_it) begin
      e.a  = a;
      e.b  = b;
      e.dz = (b == 0);
      e.q  = (b == 0) ? 8'hFF : 8'(int'(a) / int'(b));
      e.r  = (b == 0) ? 4'd0  : 4'(int'(a) % int'(b));
      e.e0 = cyc + 1;
      sb.push_back(e);
      n_start++;
    end
    @(negedge Clock);
    bus.iStart = 1'b0;
    bus.iA     = 8'($urandom);
    bus.iB     = 4'($urandom);
    repeat (gap) @(negedge Clock);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge Clock);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout %s: %0d ops still pending, need 0", name, sb.size());
      sb.delete();
    end
    repeat (2) @(negedge Clock);
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0 || bus.oQ !== 8'd0 ||
        bus.oR !== 4'd0 || bus.oDivZero !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%0b done=%0b q=%0d r=%0d dz=%0b, need all 0",
               name, bus.oBusy, bus.oDone, bus.oQ, bus.oR, bus.oDivZero);
    end
  endtask

  initial begin
    bus.iStart = 1'b0;
    bus.iA     = '0;
    bus.iB     = '0;
    repeat (3) @(negedge Clock);
    check_cleared("reset_state");
    Reset = 1'b0;

    go(8'd200, 4'd7, 1, 0);  drain("200/7");
    go(8'd255, 4'd1, 1, 0);  drain("255/1");
    go(8'd5,   4'd9, 1, 0);  drain("5/9");
    go(8'd0,   4'd15, 1, 0); drain("0/15");

    go(8'd77, 4'd0, 1, 0);   drain("77/0");
    go(8'd77, 4'd7, 1, 0);   drain("77/7");

    // A second start mid-operation must be dropped
    go(8'd100, 4'd3, 1, 0);
    repeat (2) @(negedge Clock);
    bus.iStart = 1'b1;
    bus.iA     = 8'd50;
    bus.iB     = 4'd5;
    @(negedge Clock);
    bus.iStart = 1'b0;
    drain("100/3_ignore");
    repeat (15) @(negedge Clock);

    // Abort an operation with reset; no done may follow for it
    go(8'd200, 4'd7, 0, 0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check_cleared("reset_mid_op");
    repeat (15) @(negedge Clock);
    go(8'd9, 4'd2, 1, 0);    drain("9/2");

    for (int a = 0; a < 256; a++)
      for (int b = 1; b < 16; b++)
        go(8'(a), 4'(b), 1, 8);
    drain("exhaustive");

    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      logic [3:0] rb;
      ra = 8'($urandom);
      rb = 4'($urandom_range(0, 15));
      go(ra, rb, 1, ((rb == 0) ? 0 : 8) + int'($urandom_range(0, 3)));
    end
    drain("random");

    checks++;
    if (n_done != n_start) begin
      failures++;
      $display("FAIL done_count: %0d done pulses, need %0d", n_done, n_start);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/div_ocho_bits.md
Name: div_ocho_bits

Overview:
- Sequential restoring divider: 8-bit dividend by 4-bit divisor, producing an 8-bit quotient and a 4-bit remainder.
- Inverse operation of the lab's 4x4 combinational multiplier; sits beside it in the arithmetic datapath.
- One quotient bit is resolved per clock.
- start/busy/done handshake; results are held until the next accepted operation.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; iteration count equals this value.
- DIVISOR_W, 4, divisor and remainder width; the internal partial remainder is DIVISOR_W+1 bits.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- iStart  input  1  request; sampled only in IDLE.
- iA  input  DIVIDEND_W  dividend, unsigned.
- iB  input  DIVISOR_W  divisor, unsigned.
- oBusy  output  1  high while iterating (RUN state).
- oDone  output  1  one-cycle pulse when oQ/oR/oDivZero are updated.
- oQ  output  DIVIDEND_W  quotient, registered.
- oR  output  DIVISOR_W  remainder, registered.
- oDivZero  output  1  last completed operation had divisor 0.

Behaviour:
- Clocking and reset: one clock (Clock); Reset is synchronous and active-high.
- Reset values: state=IDLE, oBusy=0, oDone=0, oQ=0, oR=0, oDivZero=0, internal regs=0. All outputs are registered.
- States are IDLE, RUN and DONE.
- IDLE:
  - If iStart=1 and iB!=0 at edge E0: latch iA into the shift register and iB into the divisor register, clear the partial remainder, set count=DIVIDEND_W-1, go to RUN.
  - If iStart=1 and iB=0: go directly to DONE with oQ=all ones (8'hFF), oR=0, oDivZero=1.
  - Otherwise stay in IDLE.
- RUN, each edge:
  - P = {R[DIVISOR_W-1:0], msb of shift reg}, which is DIVISOR_W+1 bits.
  - If P >= divisor: R = P - divisor, shift a 1 into the quotient LSB. Otherwise R = P, shift in a 0.
  - The dividend register shifts left by 1.
  - When count=0, take the final iteration, load oQ/oR from the final values, set oDivZero=0, go to DONE. Otherwise decrement count.
- DONE: lasts exactly one cycle, then returns to IDLE.
- oBusy=1 exactly while state=RUN. oDone=1 exactly while state=DONE.
- Latency for normal operation:
  - iStart sampled at edge E0; oBusy is high for DIVIDEND_W cycles after E0.
  - oDone is high in the cycle following edge E0+DIVIDEND_W, i.e. the 9th cycle after E0 for the defaults.
  - Minimum start-to-start spacing is DIVIDEND_W+2 cycles.
- Latency for divide-by-zero: oDone is high in the cycle immediately after E0; oBusy is never asserted.
- oQ, oR and oDivZero change only on the edge entering DONE and hold otherwise, including through IDLE.
- iStart while in RUN or DONE is ignored and is not queued. iA/iB changes after E0 have no effect on the operation in flight.
- Reset during RUN or DONE: back to IDLE next edge, all outputs cleared, and no oDone pulse for the aborted operation.
- Arithmetic invariants:
  - For every iB!=0: oQ*iB + oR == iA, and oR < iB.
  - oQ never overflows because the quotient width equals the dividend width.

Test Plan:
- Normal division: iA=200, iB=7, iStart one cycle -> oBusy high for 8 cycles; oDone pulse 9 cycles after start; oQ=28, oR=4, oDivZero=0.
- Edge operands:
  - iA=255, iB=1 -> oQ=255, oR=0.
  - iA=5, iB=9 -> oQ=0, oR=5.
  - iA=0, iB=15 -> oQ=0, oR=0.
- Divide by zero: iA=77, iB=0 -> oDone 1 cycle after start, oBusy stays 0; oQ=8'hFF, oR=0, oDivZero=1. A following 77/7 returns oQ=11, oR=0, oDivZero=0.
- Start ignored while busy: start 100/3, then pulse iStart with 50/5 at cycle 4 -> single oDone with oQ=33, oR=1; no second oDone appears.
- Reset mid-operation: start 200/7, assert Reset at cycle 4 -> next cycle all outputs 0 and state IDLE; no oDone. A fresh 9/2 then gives oQ=4, oR=1.
- Exhaustive self-check: all 256x15 nonzero-divisor pairs, back-to-back at minimum spacing -> every result matches iA/iB and iA%iB; oDone count equals start count.
